// File: rtl/pcihellocore_botoes_pkg.sv
// Shared constants and types for the botoes pushbutton conditioning stage.
// The counter-width helper keeps the debounce counter just wide enough for DEBOUNCE_CYCLES.
package pcihellocore_botoes_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } edge_e;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pcihellocore_debounce_bit.sv
// One input bit: synchroniser chain, stability counter, accepted level and
// one-cycle rise/fall strobes registered together with the level change.
module pcihellocore_debounce_bit
  import pcihellocore_botoes_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic x_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  edge_e                  edge_q, edge_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      edge_q  <= EDGE_NONE;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], x_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      edge_q  <= edge_d;
    end
  end

  // Any sample matching the accepted level restarts the count, so a
  // single-cycle return rejects the whole pending transition.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    edge_d  = EDGE_NONE;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = ~level_q;
      edge_d  = level_q ? EDGE_FALL : EDGE_RISE;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign db_o   = level_q;
  assign rise_o = (edge_q == EDGE_RISE);
  assign fall_o = (edge_q == EDGE_FALL);

endmodule

// File: rtl/pcihellocore_botoes_debounce.sv
// Pushbutton/switch conditioning ahead of the botoes PIO: polarity fix-up,
// per-bit debounce, sticky edge capture with write-one-to-clear and a level IRQ.
module pcihellocore_botoes_debounce
  import pcihellocore_botoes_pkg::*;
#(
  parameter int unsigned      WIDTH           = 32,
  parameter int unsigned      SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned      DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] INVERT_MASK     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] edge_clear,
  input  logic [WIDTH-1:0] irq_mask,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic             irq_q, irq_d;

  assign x = raw_in ^ INVERT_MASK;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pcihellocore_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_i (clk),
      .rst_ni(reset_n),
      .x_i   (x[i]),
      .db_o  (db_out[i]),
      .rise_o(rise_pulse[i]),
      .fall_o(fall_pulse[i])
    );
  end

  // A new strobe outranks a coincident clear so no transition is ever lost.
  always_comb begin
    edge_capture_d = (edge_capture_q & ~edge_clear) | rise_pulse | fall_pulse;
    irq_d          = |(edge_capture_q & irq_mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture_q <= '0;
      irq_q          <= 1'b0;
    end else begin
      edge_capture_q <= edge_capture_d;
      irq_q          <= irq_d;
    end
  end

  assign edge_capture = edge_capture_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_pcihellocore_botoes_debounce.sv
// Scenario and randomized bench for pcihellocore_botoes_debounce (W=4, 2 sync stages, 4-cycle debounce, bit 3 inverted).
// Reference model: a level flips once the last DEBOUNCE_CYCLES synchronised samples all disagree with it.
module tb_pcihellocore_botoes_debounce;

  localparam int unsigned W    = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DC   = 4;
  localparam logic [W-1:0] INV = 4'b1000;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] raw_in, edge_clear, irq_mask;
  logic [W-1:0] db_out, rise_pulse, fall_pulse, edge_capture;
  logic         irq;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  pcihellocore_botoes_debounce #(
    .WIDTH          (W),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DC),
    .INVERT_MASK    (INV)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .raw_in      (raw_in),
    .edge_clear  (edge_clear),
    .irq_mask    (irq_mask),
    .db_out      (db_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .edge_capture(edge_capture),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] m_db, m_rise, m_fall, m_ec;
  logic         m_irq;
  logic [W-1:0] xq[$];
  logic [W-1:0] sq[$];

  task automatic model_reset();
    m_db = '0; m_rise = '0; m_fall = '0; m_ec = '0; m_irq = 1'b0;
    xq.delete();
    sq.delete();
    repeat (SYNC) xq.push_back('0);
    repeat (DC) sq.push_back('0);
  endtask

  task automatic model_edge(input logic [W-1:0] x, input logic [W-1:0] clr, input logic [W-1:0] mask);
    logic [W-1:0] s, nrise, nfall, ndb;
    logic         all_diff;
    s = xq.pop_front();
    xq.push_back(x);
    void'(sq.pop_front());
    sq.push_back(s);
    m_irq = |(m_ec & mask);
    m_ec  = (m_ec & ~clr) | m_rise | m_fall;
    nrise = '0; nfall = '0; ndb = m_db;
    for (int i = 0; i < int'(W); i++) begin
      all_diff = 1'b1;
      foreach (sq[j]) if (sq[j][i] == m_db[i]) all_diff = 1'b0;
      if (all_diff) begin
        ndb[i] = ~m_db[i];
        if (m_db[i]) nfall[i] = 1'b1;
        else         nrise[i] = 1'b1;
      end
    end
    m_db = ndb; m_rise = nrise; m_fall = nfall;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(raw_in ^ INV, edge_clear, irq_mask);
    #1;
  endtask

  task automatic clear_all();
    edge_clear = '1;
    tick();
    edge_clear = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; raw_in = '0; edge_clear = '0; irq_mask = '0;
    #2 reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if ({db_out, rise_pulse, fall_pulse, edge_capture, irq} !== '0)
      $display("FAIL reset_state got=%b required=0", {db_out, rise_pulse, fall_pulse, edge_capture, irq});
    else pass_cnt++;
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_inversion();
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_cnt++;
      if (db_out[3] !== (k >= 6)) $display("FAIL inv_db k=%0d got=%b required=%b", k, db_out[3], k >= 6);
      else pass_cnt++;
      chk_cnt++;
      if (rise_pulse[3] !== (k == 6)) $display("FAIL inv_rise k=%0d got=%b required=%b", k, rise_pulse[3], k == 6);
      else pass_cnt++;
    end
    chk_cnt++;
    if (edge_capture !== 4'b1000) $display("FAIL inv_capture got=%b required=1000", edge_capture);
    else pass_cnt++;
    clear_all();
  endtask

  task automatic test_clean_press();
    raw_in = 4'b0001; irq_mask = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_cnt++;
      if (db_out[0] !== (k >= 6)) $display("FAIL press_db k=%0d got=%b required=%b", k, db_out[0], k >= 6);
      else pass_cnt++;
      chk_cnt++;
      if (rise_pulse[0] !== (k == 6)) $display("FAIL press_rise k=%0d got=%b required=%b", k, rise_pulse[0], k == 6);
      else pass_cnt++;
      chk_cnt++;
      if (edge_capture !== ((k >= 7) ? 4'b0001 : 4'b0000))
        $display("FAIL press_capture k=%0d got=%b required=%b", k, edge_capture, (k >= 7) ? 4'b0001 : 4'b0000);
      else pass_cnt++;
      chk_cnt++;
      if (irq !== (k >= 8)) $display("FAIL press_irq k=%0d got=%b required=%b", k, irq, k >= 8);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    for (int k = 1; k <= 13; k++) begin
      raw_in = (k <= 3) ? 4'b0011 : 4'b0001;
      tick();
      chk_cnt++;
      if ({db_out[1], rise_pulse[1], fall_pulse[1], edge_capture[1]} !== 4'b0000)
        $display("FAIL glitch k=%0d got=%b required=0000", k,
                 {db_out[1], rise_pulse[1], fall_pulse[1], edge_capture[1]});
      else pass_cnt++;
    end
  endtask

  task automatic test_bounce();
    int rises;
    logic [W-1:0] pat[4];
    pat = '{4'b0101, 4'b0001, 4'b0101, 4'b0001};
    rises = 0;
    foreach (pat[j]) begin
      raw_in = pat[j];
      tick();
      if (rise_pulse[2]) rises++;
    end
    raw_in = 4'b0101;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (rise_pulse[2]) rises++;
      chk_cnt++;
      if (rise_pulse[2] !== (k == 6)) $display("FAIL bounce_rise k=%0d got=%b required=%b", k, rise_pulse[2], k == 6);
      else pass_cnt++;
    end
    chk_cnt++;
    if (rises != 1) $display("FAIL bounce_count got=%0d required=1", rises);
    else pass_cnt++;
  endtask

  task automatic test_clear_race();
    clear_all();
    tick();
    raw_in = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_cnt++;
      if (fall_pulse[0] !== (k == 6)) $display("FAIL race_fall k=%0d got=%b required=%b", k, fall_pulse[0], k == 6);
      else pass_cnt++;
    end
    edge_clear = 4'b0001;
    tick();
    chk_cnt++;
    if ({edge_capture[0], irq} !== 2'b10) $display("FAIL race_set_wins got=%b required=10", {edge_capture[0], irq});
    else pass_cnt++;
    tick();
    edge_clear = '0;
    chk_cnt++;
    if ({edge_capture[0], irq} !== 2'b01) $display("FAIL race_clear got=%b required=01", {edge_capture[0], irq});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL race_irq_drop got=%b required=0", irq);
    else pass_cnt++;
  endtask

  task automatic test_reset_midcount();
    raw_in = 4'b0001;
    repeat (5) tick();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk_cnt++;
    if ({db_out, rise_pulse, fall_pulse, edge_capture, irq} !== '0)
      $display("FAIL midreset_async got=%b required=0", {db_out, rise_pulse, fall_pulse, edge_capture, irq});
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_cnt++;
      if (db_out !== ((k >= 6) ? 4'b1001 : 4'b0000))
        $display("FAIL midreset_db k=%0d got=%b required=%b", k, db_out, (k >= 6) ? 4'b1001 : 4'b0000);
      else pass_cnt++;
      chk_cnt++;
      if (rise_pulse !== ((k == 6) ? 4'b1001 : 4'b0000))
        $display("FAIL midreset_rise k=%0d got=%b required=%b", k, rise_pulse, (k == 6) ? 4'b1001 : 4'b0000);
      else pass_cnt++;
    end
  endtask

  task automatic test_parallel();
    raw_in = 4'b1110;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_cnt++;
      if ({rise_pulse, fall_pulse} !== ((k == 6) ? 8'b0110_1001 : 8'b0))
        $display("FAIL parallel_pulses k=%0d got=%b required=%b", k, {rise_pulse, fall_pulse},
                 (k == 6) ? 8'b0110_1001 : 8'b0);
      else pass_cnt++;
      chk_cnt++;
      if (db_out !== ((k >= 6) ? 4'b0110 : 4'b1001))
        $display("FAIL parallel_db k=%0d got=%b required=%b", k, db_out, (k >= 6) ? 4'b0110 : 4'b1001);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < int'(W); i++)
        if ($urandom_range(0, 5) == 0) raw_in[i] = ~raw_in[i];
      edge_clear = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      if ($urandom_range(0, 49) == 0) irq_mask = W'($urandom);
      tick();
      chk_cnt++;
      if (db_out !== m_db) $display("FAIL rand_db c=%0d got=%b required=%b", c, db_out, m_db);
      else pass_cnt++;
      chk_cnt++;
      if (rise_pulse !== m_rise) $display("FAIL rand_rise c=%0d got=%b required=%b", c, rise_pulse, m_rise);
      else pass_cnt++;
      chk_cnt++;
      if (fall_pulse !== m_fall) $display("FAIL rand_fall c=%0d got=%b required=%b", c, fall_pulse, m_fall);
      else pass_cnt++;
      chk_cnt++;
      if (edge_capture !== m_ec) $display("FAIL rand_capture c=%0d got=%b required=%b", c, edge_capture, m_ec);
      else pass_cnt++;
      chk_cnt++;
      if (irq !== m_irq) $display("FAIL rand_irq c=%0d got=%b required=%b", c, irq, m_irq);
      else pass_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_inversion();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_clear_race();
    test_reset_midcount();
    test_parallel();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
